// File: rtl/scarv_cop_issue.sv
// scarv_cop_issue
// ----------------
// Issues one instruction at a time from the core to a coprocessor (COP) and
// returns the COP's writeback response to the core.
//
// Handshakes: a transfer happens on a rising g_clk edge when valid and ready
// are both high. Valid-side signals are held stable until that edge, and the
// valid side never waits for ready before asserting valid. The same rule
// applies to core_req_*, core_rsp_*, cpu_insn_req/cpu_insn_ack and
// cop_insn_rsp/cop_insn_ack.
//
// Ports
//   g_clk, g_resetn          clock, asynchronous active-low reset
//   core_req_valid/ready     core -> issue: instruction request
//   core_req_insn[31:0]      encoded instruction
//   core_rsp_valid/ready     issue -> core: response
//   core_rsp_result[2:0]     COP result code, 110 = not an ISE insn, 111 = timeout
//   core_rsp_wen/waddr/wdata GPR writeback
//   cpu_insn_req/ack         issue -> COP: instruction request
//   cpu_insn_enc[31:0]       registered instruction sent to the COP
//   cop_insn_rsp/ack         COP -> issue: response
//   cop_result/wen/waddr/wdata COP response payload
//   busy                     high whenever a transaction is in flight
//   dbg_state[1:0]           current FSM state (0 IDLE, 1 REQ, 2 RSP, 3 DONE)
module scarv_cop_issue #(
    parameter int TIMEOUT = 255
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        core_req_valid,
    output logic        core_req_ready,
    input  logic [31:0] core_req_insn,
    output logic        core_rsp_valid,
    input  logic        core_rsp_ready,
    output logic [2:0]  core_rsp_result,
    output logic        core_rsp_wen,
    output logic [4:0]  core_rsp_waddr,
    output logic [31:0] core_rsp_wdata,
    output logic        cpu_insn_req,
    input  logic        cpu_insn_ack,
    output logic [31:0] cpu_insn_enc,
    input  logic        cop_insn_rsp,
    output logic        cop_insn_ack,
    input  logic [2:0]  cop_result,
    input  logic        cop_wen,
    input  logic [4:0]  cop_waddr,
    input  logic [31:0] cop_wdata,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] RES_NOT_ISE = 3'b110;
    localparam logic [2:0] RES_TIMEOUT = 3'b111;
    // Counter value on the last RSP cycle before giving up.
    localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] insn_q;
    logic [7:0]  cnt_q;
    logic [2:0]  result_q;
    logic        wen_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;
    logic        is_ise;
    logic        timed_out;

    // ISE instructions use the custom-0..3 major opcodes.
    always_comb begin
        is_ise = 1'b0;
        case (core_req_insn[6:0])
            7'b0001011, 7'b0101011, 7'b1011011, 7'b1111011: is_ise = 1'b1;
            default:                                        is_ise = 1'b0;
        endcase
    end

    assign timed_out = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (core_req_valid) state_d = is_ise ? S_REQ : S_DONE;
            S_REQ:  if (cpu_insn_ack) state_d = S_RSP;
            // A response in the last counted cycle wins over the timeout.
            S_RSP:  if (cop_insn_rsp || timed_out) state_d = S_DONE;
            S_DONE: if (core_rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q  <= S_IDLE;
            insn_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            wen_q    <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (core_req_valid) begin
                        insn_q <= core_req_insn;
                        if (!is_ise) begin
                            result_q <= RES_NOT_ISE;
                            wen_q    <= 1'b0;
                            waddr_q  <= '0;
                            wdata_q  <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (cpu_insn_ack) cnt_q <= '0;
                end
                S_RSP: begin
                    if (cop_insn_rsp) begin
                        result_q <= cop_result;
                        // Error codes never write back, whatever the COP says.
                        wen_q    <= cop_wen && (cop_result != RES_NOT_ISE)
                                           && (cop_result != RES_TIMEOUT);
                        waddr_q  <= cop_waddr;
                        wdata_q  <= cop_wdata;
                    end else if (timed_out) begin
                        result_q <= RES_TIMEOUT;
                        wen_q    <= 1'b0;
                        waddr_q  <= '0;
                        wdata_q  <= '0;
                    end else if (cnt_q != 8'hff) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_req_ready  = (state_q == S_IDLE);
    assign core_rsp_valid  = (state_q == S_DONE);
    assign cpu_insn_req    = (state_q == S_REQ);
    assign cop_insn_ack    = (state_q == S_RSP) && cop_insn_rsp;
    assign busy            = (state_q != S_IDLE);
    assign dbg_state       = state_q;
    assign cpu_insn_enc    = insn_q;
    assign core_rsp_result = result_q;
    assign core_rsp_wen    = wen_q;
    assign core_rsp_waddr  = waddr_q;
    assign core_rsp_wdata  = wdata_q;

endmodule

// File: tb/tb_scarv_cop_issue.sv
// Testbench for scarv_cop_issue, built with TIMEOUT=4 so timeouts are reachable.
module tb_scarv_cop_issue;

    localparam int TO = 4;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        core_req_valid = 1'b0;
    logic        core_req_ready;
    logic [31:0] core_req_insn = '0;
    logic        core_rsp_valid;
    logic        core_rsp_ready = 1'b0;
    logic [2:0]  core_rsp_result;
    logic        core_rsp_wen;
    logic [4:0]  core_rsp_waddr;
    logic [31:0] core_rsp_wdata;
    logic        cpu_insn_req;
    logic        cpu_insn_ack = 1'b0;
    logic [31:0] cpu_insn_enc;
    logic        cop_insn_rsp = 1'b0;
    logic        cop_insn_ack;
    logic [2:0]  cop_result = '0;
    logic        cop_wen = 1'b0;
    logic [4:0]  cop_waddr = '0;
    logic [31:0] cop_wdata = '0;
    logic        busy;
    logic [1:0]  dbg_state;

    scarv_cop_issue #(.TIMEOUT(TO)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_insn(core_req_insn),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
        .core_rsp_result(core_rsp_result), .core_rsp_wen(core_rsp_wen),
        .core_rsp_waddr(core_rsp_waddr), .core_rsp_wdata(core_rsp_wdata),
        .cpu_insn_req(cpu_insn_req), .cpu_insn_ack(cpu_insn_ack),
        .cpu_insn_enc(cpu_insn_enc),
        .cop_insn_rsp(cop_insn_rsp), .cop_insn_ack(cop_insn_ack),
        .cop_result(cop_result), .cop_wen(cop_wen),
        .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 g_clk = ~g_clk;

    // ---------------- vectors ----------------
    // ack_dly: REQ cycles before cpu_insn_ack; rsp_dly: RSP cycle index of the
    // COP response; rdy_dly: DONE cycles with core_rsp_ready low; spur: pulse
    // cop_insn_rsp (with junk payload) in the ack cycle.
    typedef struct {
        logic [31:0] insn;
        int          ack_dly;
        int          rsp_dly;
        logic [2:0]  res;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int          rdy_dly;
        logic        spur;
        logic [2:0]  e_res;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        int          e_lat;
    } vec_t;

    vec_t vecs[9];

    int n_cmp = 0;
    int n_bad = 0;
    logic [40:0] exp_q[$];
    logic        full_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what the core must see, from the opcode and the COP timing.
    task automatic ref_model(inout vec_t v);
        logic [6:0] op;
        op = v.insn[6:0];
        if (!(op == 7'h0B || op == 7'h2B || op == 7'h5B || op == 7'h7B)) begin
            v.e_res = 3'b110; v.e_wen = 1'b0; v.e_waddr = '0; v.e_wdata = '0;
            v.e_lat = 1;
        end else if (v.rsp_dly <= TO - 1) begin
            v.e_res = v.res;
            v.e_wen = v.wen && (v.res < 3'd6);
            v.e_waddr = v.waddr; v.e_wdata = v.wdata;
            v.e_lat = 1 + (v.ack_dly + 1) + (v.rsp_dly + 1);
        end else begin
            v.e_res = 3'b111; v.e_wen = 1'b0; v.e_waddr = '0; v.e_wdata = '0;
            v.e_lat = 1 + (v.ack_dly + 1) + TO;
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [40:0] e, input logic full);
        chk({tag, ".valid"}, core_rsp_valid, 1);
        chk({tag, ".result"}, core_rsp_result, e[40:38]);
        chk({tag, ".wen"}, core_rsp_wen, e[37]);
        if (full) begin
            chk({tag, ".waddr"}, core_rsp_waddr, e[36:32]);
            chk({tag, ".wdata"}, core_rsp_wdata, e[31:0]);
        end
    endtask

    // Driver: one full transaction. Called at #1 after a rising edge with DUT idle.
    task automatic run_txn(input vec_t v);
        int lat, req_cyc, k;
        logic acked, seen_req, full;
        logic [40:0] e;
        exp_q.push_back({v.e_res, v.e_wen, v.e_waddr, v.e_wdata});
        full_q.push_back(v.e_res != 3'b111);
        cop_result = v.res; cop_wen = v.wen; cop_waddr = v.waddr; cop_wdata = v.wdata;
        chk("req_ready_idle", core_req_ready, 1);
        core_req_valid = 1'b1;
        core_req_insn  = v.insn;
        @(posedge g_clk); #1;
        core_req_valid = 1'b0;
        core_req_insn  = $urandom;
        lat = 1; req_cyc = 0; k = 0; acked = 1'b0; seen_req = 1'b0;
        while (!core_rsp_valid && lat < 60) begin
            if (cpu_insn_req) begin
                seen_req = 1'b1;
                chk("insn_enc", cpu_insn_enc, v.insn);
                if (req_cyc == v.ack_dly) begin
                    cpu_insn_ack = 1'b1;
                    acked = 1'b1;
                    if (v.spur) begin
                        cop_insn_rsp = 1'b1;
                        cop_result = ~v.res;
                        cop_wdata = ~v.wdata;
                    end
                end
                #1 chk("cop_ack_outside_rsp", cop_insn_ack, 0);
                req_cyc++;
            end else if (acked) begin
                cop_insn_rsp = (k == v.rsp_dly);
                #1 chk("cop_ack_in_rsp", cop_insn_ack, cop_insn_rsp);
                k++;
            end
            @(posedge g_clk); #1;
            lat++;
            cpu_insn_ack = 1'b0; cop_insn_rsp = 1'b0;
            cop_result = v.res; cop_wdata = v.wdata;
        end
        chk("latency", lat, v.e_lat);
        chk("cop_req_seen", seen_req, v.e_lat > 1);
        e = exp_q.pop_front();
        full = full_q.pop_front();
        // Offer a new request while the response is pending; it must be refused.
        for (int b = 0; b < v.rdy_dly; b++) begin
            core_rsp_ready = 1'b0;
            core_req_valid = 1'b1;
            core_req_insn = 32'h0000_002B;
            chk_rsp("hold", e, full);
            chk("req_ready_hold", core_req_ready, 0);
            @(posedge g_clk); #1;
        end
        core_rsp_ready = 1'b1;
        core_req_valid = 1'b1;
        core_req_insn = 32'h0000_002B;
        chk_rsp("rsp", e, full);
        chk("req_ready_done", core_req_ready, 0);
        @(posedge g_clk); #1;
        core_rsp_ready = 1'b0;
        core_req_valid = 1'b0;
        chk("valid_after_consume", core_rsp_valid, 0);
        chk("busy_after_consume", busy, 0);
        chk("req_ready_after", core_req_ready, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".cpu_insn_req"}, cpu_insn_req, 0);
        chk({tag, ".cop_insn_ack"}, cop_insn_ack, 0);
        chk({tag, ".core_rsp_valid"}, core_rsp_valid, 0);
        chk({tag, ".core_rsp_wen"}, core_rsp_wen, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".core_rsp_result"}, core_rsp_result, 0);
        chk({tag, ".core_rsp_waddr"}, core_rsp_waddr, 0);
        chk({tag, ".core_rsp_wdata"}, core_rsp_wdata, 0);
        chk({tag, ".cpu_insn_enc"}, cpu_insn_enc, 0);
    endtask

    // ---------------- test ----------------
    initial begin
        vec_t v;
        vecs[0] = '{32'h0000002B, 0, 0, 3'd0, 1'b1, 5'd5,  32'hDEADBEEF, 0, 1'b0, 3'd0, 1'b1, 5'd5,  32'hDEADBEEF, 3};
        vecs[1] = '{32'h00000033, 0, 0, 3'd2, 1'b1, 5'd4,  32'h00001111, 0, 1'b0, 3'd6, 1'b0, 5'd0,  32'h0,        1};
        vecs[2] = '{32'h0000100B, 10, 1, 3'd2, 1'b1, 5'd7, 32'h00001234, 0, 1'b1, 3'd2, 1'b1, 5'd7,  32'h00001234, 14};
        vecs[3] = '{32'hABCD005B, 0, 9, 3'd1, 1'b1, 5'd1,  32'h00000001, 0, 1'b0, 3'd7, 1'b0, 5'd0,  32'h0,        6};
        vecs[4] = '{32'h0000007B, 0, 3, 3'd1, 1'b1, 5'd31, 32'hA5A5A5A5, 0, 1'b0, 3'd1, 1'b1, 5'd31, 32'hA5A5A5A5, 6};
        vecs[5] = '{32'h0000002B, 2, 1, 3'd4, 1'b0, 5'd3,  32'h000000FF, 5, 1'b0, 3'd4, 1'b0, 5'd3,  32'h000000FF, 6};
        vecs[6] = '{32'h0000000B, 0, 0, 3'd6, 1'b1, 5'd9,  32'h00000009, 0, 1'b0, 3'd6, 1'b0, 5'd9,  32'h00000009, 3};
        vecs[7] = '{32'h0000003B, 0, 0, 3'd3, 1'b1, 5'd2,  32'h00000002, 1, 1'b0, 3'd6, 1'b0, 5'd0,  32'h0,        1};
        vecs[8] = '{32'h0000005B, 1, 2, 3'd7, 1'b1, 5'd8,  32'h00000008, 0, 1'b0, 3'd7, 1'b0, 5'd8,  32'h00000008, 6};

        // reset
        #2;
        chk_reset_outputs("reset");
        chk("reset.req_ready", core_req_ready, 1);
        @(posedge g_clk); @(posedge g_clk); #1;
        g_resetn = 1'b1;
        @(posedge g_clk); #1;

        // directed table (entries 0-5 leave nonzero response registers behind)
        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // reset while waiting for the COP response
        core_req_valid = 1'b1; core_req_insn = 32'h0000122B;
        @(posedge g_clk); #1;
        core_req_valid = 1'b0;
        chk("rst_seq.in_req", cpu_insn_req, 1);
        cpu_insn_ack = 1'b1;
        @(posedge g_clk); #1;
        cpu_insn_ack = 1'b0;
        chk("rst_seq.busy_rsp", busy, 1);
        cop_insn_rsp = 1'b1;
        g_resetn = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(posedge g_clk); #1;
        cop_insn_rsp = 1'b0;
        g_resetn = 1'b1;
        chk("rst_seq.req_ready", core_req_ready, 1);
        chk("rst_seq.busy", busy, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge g_clk); #1;
            chk("rst_seq.no_rsp", core_rsp_valid, 0);
        end
        run_txn(vecs[0]);

        for (int i = 6; i < 9; i++) run_txn(vecs[i]);

        // randomized transactions against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [6:0] ops[4];
            int sel;
            ops[0] = 7'h0B; ops[1] = 7'h2B; ops[2] = 7'h5B; ops[3] = 7'h7B;
            v.insn = $urandom;
            sel = $urandom_range(0, 5);
            if (sel < 4) v.insn[6:0] = ops[sel];
            v.ack_dly = $urandom_range(0, 3);
            v.rsp_dly = $urandom_range(0, 5);
            v.res = 3'($urandom_range(0, 7));
            v.wen = 1'($urandom_range(0, 1));
            v.waddr = 5'($urandom_range(0, 31));
            v.wdata = $urandom;
            v.rdy_dly = $urandom_range(0, 2);
            v.spur = 1'($urandom_range(0, 1));
            ref_model(v);
            run_txn(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scarv_cop_issue.md
SCARV_COP_ISSUE -- requirements
Module: scarv_cop_issue

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: the number of cycles to wait for a COP response, counted from request acceptance.
REQ-002 SHALL have port g_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port g_resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have core-side request ports:
- core_req_valid, input, 1
- core_req_ready, output, 1
- core_req_insn, input, 32: the encoded instruction.
REQ-005 SHALL have core-side response ports:
- core_rsp_valid, output, 1
- core_rsp_ready, input, 1
- core_rsp_result, output, 3
- core_rsp_wen, output, 1
- core_rsp_waddr, output, 5
- core_rsp_wdata, output, 32
REQ-006 SHALL have COP request ports:
- cpu_insn_req, output, 1
- cpu_insn_ack, input, 1
- cpu_insn_enc, output, 32
REQ-007 SHALL have COP response ports:
- cop_insn_rsp, input, 1
- cop_insn_ack, output, 1
- cop_result, input, 3
- cop_wen, input, 1
- cop_waddr, input, 5
- cop_wdata, input, 32
REQ-008 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-009 SHALL implement a four-state FSM:
- IDLE: core_req_ready=1.
- REQ: cpu_insn_req=1; cpu_insn_enc is the registered instruction.
- RSP: waiting for the COP response.
- DONE: core_rsp_valid=1.
REQ-010 SHALL, in IDLE with core_req_valid=1, register core_req_insn and then branch:
- If insn[6:0] is one of 0001011, 0101011, 1011011, 1111011: go to REQ.
- Otherwise: go to DONE with result 3'b110, wen=0, waddr=0, wdata=0. No COP request is made.
REQ-011 SHALL hold cpu_insn_req and cpu_insn_enc stable in REQ until cpu_insn_ack=1. On that edge the FSM goes to RSP and the timeout counter clears to 0.
REQ-012 SHALL never drive cpu_insn_req combinationally from core_req_valid; the earliest COP request is one cycle after core acceptance.
REQ-013 SHALL, in RSP, drive cop_insn_ack=1 combinationally whenever cop_insn_rsp=1. On that edge it captures cop_result, cop_wen, cop_waddr, cop_wdata and goes to DONE.
REQ-014 SHALL ignore cop_insn_rsp in every state other than RSP, including a response in the same cycle as cpu_insn_ack.
REQ-015 SHALL handle the timeout counter as follows:
- Width is 8 bits; it increments each RSP cycle without a response.
- It saturates and never wraps.
- When it equals TIMEOUT-1 with no response: go to DONE, result 3'b111, wen=0.
- A response arriving in that same cycle takes priority over the timeout.
REQ-016 SHALL hold all core_rsp_* outputs stable in DONE until core_rsp_ready=1, then go to IDLE.
REQ-017 SHALL make core_req_ready low in DONE, so no new request is accepted in the same cycle the response is consumed.
REQ-018 SHALL drive core_rsp_wen only from the captured cop_wen, and force it to 0 for result codes 3'b110 and 3'b111.
REQ-019 SHALL give a minimum latency, core acceptance to core_rsp_valid, of:
- 3 cycles for an ISE instruction with immediate ack and response;
- 1 cycle for a non-ISE instruction.

Reset
REQ-020 SHALL, while g_resetn=0, immediately force:
- state to IDLE and the counter to 0;
- cpu_insn_req, cop_insn_ack, core_rsp_valid, core_rsp_wen and busy to 0;
- core_rsp_result, core_rsp_waddr, core_rsp_wdata and cpu_insn_enc to 0.
REQ-021 SHALL, on reset asserted mid-transaction (REQ/RSP/DONE), abandon the transaction without emitting a response; after reset release the block is in IDLE with core_req_ready=1.

Verification
REQ-022 SHALL pass these directed scenarios:
- Basic ISE: insn 0x0000002B; ack in cycle 1, rsp in cycle 2 with result 0, wen=1, waddr=5, wdata=0xDEADBEEF -> core_rsp_valid with those values 3 cycles after acceptance.
- Non-ISE: insn 0x00000033 -> cpu_insn_req never high; core_rsp_valid next cycle with result 3'b110, wen=0.
- Ack stall: cpu_insn_ack held low for 10 cycles -> cpu_insn_req and enc stable for all 10 cycles; cop_insn_rsp pulsed in the ack cycle is ignored.
- Timeout: TIMEOUT=4, no response -> DONE after 4 RSP cycles with result 3'b111, wen=0. A response on the 4th cycle yields the COP result instead.
- Back-pressure: core_rsp_ready low for 5 cycles -> all core_rsp_* outputs unchanged and core_req_ready=0 throughout.
- Reset in RSP: g_resetn pulsed low -> outputs are zero asynchronously, no response is emitted, and the next instruction completes normally.
